// File: rtl/ex_alu_arb_pkg.sv
// Shared ALU definitions: opcode encodings, opcode width, legality decode
// and the arbiter state type.
package ex_alu_arb_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ = 4'b1100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_BEQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational execute-stage ALU. BEQ raises branch when a == b and yields
// result 0; unsupported opcodes also yield result 0.
module ex_alu
    import ex_alu_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [W-1:0]        result,
    output logic                branch
);

    always_comb begin
        result = '0;
        branch = 1'b0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_MUL: result = a * b;
            ALU_BEQ: branch = (a == b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_arb.sv
// Two-requester round-robin arbiter with a one-entry response register in
// front of a shared ex_alu. Optional perf counters: define ALU_ARB_PERF_EN.
module ex_alu_arb
    import ex_alu_arb_pkg::*;
#(
    parameter int W    = 32,
    parameter int ID_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [W-1:0]        req0_a,
    input  logic [W-1:0]        req0_b,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [W-1:0]        req1_a,
    input  logic [W-1:0]        req1_b,
    input  logic [ALU_OP_W-1:0] req1_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [W-1:0]        rsp_result,
    output logic                rsp_branch,
    output logic                rsp_illegal
`ifdef ALU_ARB_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [15:0]         perf_grant0,
    output logic [15:0]         perf_grant1,
    output logic [15:0]         perf_stall
`endif
);

    arb_state_t            state, state_nxt;
    logic                  can_accept;
    logic                  grant0, grant1;
    logic                  accept;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       last_grant;
    logic [W-1:0]          a_q, b_q;
    logic [ALU_OP_W-1:0]   op_q;
    logic [ID_W-1:0]       id_q;
    logic                  illegal_q;

    // Round-robin pick: a lone requester always wins; on a tie the one that
    // was not granted last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant == ID_W'(1)) grant0 = 1'b1;
            else                        grant1 = 1'b1;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign grant_id = grant1 ? ID_W'(1) : '0;

    always_comb begin
        state_nxt  = state;
        can_accept = (state == ST_EMPTY) || rsp_ready;
        accept     = can_accept && (grant0 || grant1);
        req0_ready = can_accept && grant0;
        req1_ready = can_accept && grant1;
        rsp_valid  = (state == ST_FULL);
        if (accept)
            state_nxt = ST_FULL;
        else if (state == ST_FULL && rsp_ready)
            state_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_ADD;
            id_q       <= '0;
            illegal_q  <= 1'b0;
            last_grant <= ID_W'(1);
        end else if (accept) begin
            a_q        <= grant1 ? req1_a  : req0_a;
            b_q        <= grant1 ? req1_b  : req0_b;
            op_q       <= grant1 ? req1_op : req0_op;
            id_q       <= grant_id;
            illegal_q  <= !alu_op_legal(grant1 ? req1_op : req0_op);
            last_grant <= grant_id;
        end
    end

    ex_alu #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (rsp_result),
        .branch (rsp_branch)
    );

    assign rsp_id      = id_q;
    assign rsp_illegal = illegal_q;

`ifdef ALU_ARB_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else if (perf_clr) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept && grant0) perf_grant0 <= sat_inc(perf_grant0);
            if (accept && grant1) perf_grant1 <= sat_inc(perf_grant1);
            if (state == ST_FULL && !rsp_ready) perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_ex_alu_arb.sv
// Directed bench for ex_alu_arb: a transaction-level model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_ex_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_branch, rsp_illegal;
`ifdef ALU_ARB_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

    int tests = 0;
    int fails = 0;

    ex_alu_arb #(.W(32), .ID_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_branch(rsp_branch), .rsp_illegal(rsp_illegal)
`ifdef ALU_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_grant0(perf_grant0),
        .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a one-slot response holder and the last requester served.
    logic        m_full;
    logic        m_last;
    logic        m_id;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;

    function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return a & b;
            4'b0110: return a | b;
            4'b1000: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1000, 4'b1100};
    endfunction

    // Which requester would be served now, -1 if none may be accepted.
    function automatic int model_pick(input logic full, input logic last);
        if (full && !rsp_ready) return -1;
        if (req0_valid && req1_valid) return last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0; m_last <= 1'b1; m_id <= 1'b0;
            m_a <= '0; m_b <= '0; m_op <= '0;
        end else begin
            int p;
            p = model_pick(m_full, m_last);
            if (p == 0) begin
                m_full <= 1'b1; m_last <= 1'b0; m_id <= 1'b0;
                m_a <= req0_a; m_b <= req0_b; m_op <= req0_op;
            end else if (p == 1) begin
                m_full <= 1'b1; m_last <= 1'b1; m_id <= 1'b1;
                m_a <= req1_a; m_b <= req1_b; m_op <= req1_op;
            end else if (m_full && rsp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int p;
        p = model_pick(m_full, m_last);
        check("mdl_req0_ready", {31'd0, req0_ready}, {31'd0, p == 0});
        check("mdl_req1_ready", {31'd0, req1_ready}, {31'd0, p == 1});
        check("mdl_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
        if (m_full) begin
            check("mdl_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            check("mdl_rsp_illegal", {31'd0, rsp_illegal}, {31'd0, !is_legal(m_op)});
            check("mdl_rsp_branch", {31'd0, rsp_branch}, {31'd0, m_op == 4'b1100 && m_a == m_b});
            if (is_legal(m_op))
                check("mdl_rsp_result", rsp_result, exp_result(m_a, m_b, m_op));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_branch", {31'd0, rsp_branch}, 32'd0);
        rst_n = 1'b1;
        step();

        // Contention: grants alternate 0,1,0,1
        req0_valid = 1; req0_a = 10; req0_b = 5; req0_op = 4'b1000;
        req1_valid = 1; req1_a = 10; req1_b = 5; req1_op = 4'b0001;
        rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_req0_ready", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_req1_ready", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            check("rr_rsp_id", {31'd0, rsp_id}, k % 2);
            check("rr_rsp_result", rsp_result, (k % 2 == 0) ? 32'd50 : 32'd5);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        check("rr_drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Single request, no contention
        req0_valid = 1; req0_a = 10; req0_b = 5; req0_op = 4'b0000;
        #1;
        check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 0;
        check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("single_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("single_rsp_result", rsp_result, 32'd15);
        check("single_rsp_branch", {31'd0, rsp_branch}, 32'd0);
        step();
        check("single_drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Backpressure with back-to-back accept on release
        req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 4'b1100;
        rsp_ready = 0;
        step();
        req1_valid = 0;
        req0_valid = 1; req0_a = 7; req0_b = 5; req0_op = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_branch", {31'd0, rsp_branch}, 32'd1);
            check("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
            check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
            step();
        end
        rsp_ready = 1;
        #1;
        check("bp_release_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 0;
        check("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_next_result", rsp_result, 32'd5);
        check("bp_next_id", {31'd0, rsp_id}, 32'd0);
        step();

        // Illegal opcode followed by a legal OR
        req0_valid = 1; req0_a = 8; req0_b = 5; req0_op = 4'b1111;
        step();
        check("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("ill_rsp_illegal", {31'd0, rsp_illegal}, 32'd1);
        req0_op = 4'b0110;
        step();
        req0_valid = 0;
        check("or_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        check("or_rsp_result", rsp_result, 32'd13);
        step();

        // Asynchronous reset while stalled
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 4'b0000;
        rsp_ready = 0;
        step();
        req1_valid = 0;
        check("ar_full_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("ar_dropped_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        rst_n = 1;
        req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 4'b0000;
        req1_valid = 1; req1_a = 9; req1_b = 1; req1_op = 4'b0001;
        rsp_ready = 1;
        #1;
        check("ar_tie_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("ar_tie_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 0; req1_valid = 0;
        check("ar_tie_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("ar_tie_rsp_result", rsp_result, 32'd4);
        step();

`ifdef ALU_ARB_PERF_EN
        perf_clr = 1;
        step();
        perf_clr = 0;
        req0_valid = 1; req0_op = 4'b0000;
        repeat (4) step();
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'b0000;
        repeat (2) step();
        req1_valid = 0;
        rsp_ready = 0;
        repeat (3) step();
        rsp_ready = 1;
        check("perf_grant0", {16'd0, perf_grant0}, 32'd4);
        check("perf_grant1", {16'd0, perf_grant1}, 32'd2);
        check("perf_stall", {16'd0, perf_stall}, 32'd3);
        perf_clr = 1;
        step();
        perf_clr = 0;
        check("perf_clr_grant0", {16'd0, perf_grant0}, 32'd0);
        check("perf_clr_grant1", {16'd0, perf_grant1}, 32'd0);
        check("perf_clr_stall", {16'd0, perf_stall}, 32'd0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
